// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel (AR/R) between i_cache and d_cache.
// One burst is owned at a time; returned beats are steered only to the owning port.
module axi_rd_arbiter #(
  parameter logic [3:0] ID_I  = 4'd0,
  parameter logic [3:0] ID_D  = 4'd1,
  parameter bit         RR_EN = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] i_araddr_i,
  input  logic [7:0]  i_arlen_i,
  input  logic [2:0]  i_arsize_i,
  input  logic        i_arvalid_i,
  output logic        i_arready_o,
  output logic [31:0] i_rdata_o,
  output logic        i_rlast_o,
  output logic        i_rvalid_o,
  input  logic        i_rready_i,
  input  logic [31:0] d_araddr_i,
  input  logic [7:0]  d_arlen_i,
  input  logic [2:0]  d_arsize_i,
  input  logic        d_arvalid_i,
  output logic        d_arready_o,
  output logic [31:0] d_rdata_o,
  output logic        d_rlast_o,
  output logic        d_rvalid_o,
  input  logic        d_rready_i,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic        rd_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic [1:0] {G_NONE, G_I, G_D} grant_t;

  state_t      state_q;
  grant_t      grant_q;
  logic        last_d_q;
  logic [7:0]  cnt_q;
  logic        arvalid_q;
  logic        i_arready_q;
  logic        d_arready_q;
  logic        rd_err_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [2:0]  arsize_q;

  logic pick_d;
  logic data_i;
  logic data_d;
  logic r_hs;
  logic beat_err;

  // On a tie with round-robin enabled, the port that did not own the last burst wins.
  always_comb begin
    pick_d = d_arvalid_i;
    if (RR_EN && d_arvalid_i && i_arvalid_i) begin
      pick_d = !last_d_q;
    end
  end

  assign data_i   = (state_q == S_DATA) && (grant_q == G_I);
  assign data_d   = (state_q == S_DATA) && (grant_q == G_D);
  assign rready_o = (data_i & i_rready_i) | (data_d & d_rready_i);
  assign r_hs     = rvalid_i & rready_o;
  assign beat_err = (rid_i != arid_q) || (rlast_i != (cnt_q == arlen_q));

  assign i_rvalid_o = data_i & rvalid_i;
  assign d_rvalid_o = data_d & rvalid_i;
  assign i_rlast_o  = data_i & rlast_i;
  assign d_rlast_o  = data_d & rlast_i;
  assign i_rdata_o  = rdata_i;
  assign d_rdata_o  = rdata_i;

  assign arvalid_o   = arvalid_q;
  assign arid_o      = arid_q;
  assign araddr_o    = araddr_q;
  assign arlen_o     = arlen_q;
  assign arsize_o    = arsize_q;
  assign i_arready_o = i_arready_q;
  assign d_arready_o = d_arready_q;
  assign rd_err_o    = rd_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      grant_q     <= G_NONE;
      last_d_q    <= 1'b0;
      cnt_q       <= 8'd0;
      arvalid_q   <= 1'b0;
      i_arready_q <= 1'b0;
      d_arready_q <= 1'b0;
      rd_err_q    <= 1'b0;
      arid_q      <= 4'd0;
      araddr_q    <= 32'd0;
      arlen_q     <= 8'd0;
      arsize_q    <= 3'd0;
    end else begin
      i_arready_q <= 1'b0;
      d_arready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_arvalid_i || d_arvalid_i) begin
            state_q   <= S_ADDR;
            arvalid_q <= 1'b1;
            // AR fields are captured here so they stay stable while waiting for arready.
            if (pick_d) begin
              grant_q  <= G_D;
              arid_q   <= ID_D;
              araddr_q <= d_araddr_i;
              arlen_q  <= d_arlen_i;
              arsize_q <= d_arsize_i;
            end else begin
              grant_q  <= G_I;
              arid_q   <= ID_I;
              araddr_q <= i_araddr_i;
              arlen_q  <= i_arlen_i;
              arsize_q <= i_arsize_i;
            end
          end
        end
        S_ADDR: begin
          if (arready_i) begin
            state_q     <= S_DATA;
            arvalid_q   <= 1'b0;
            cnt_q       <= 8'd0;
            i_arready_q <= (grant_q == G_I);
            d_arready_q <= (grant_q == G_D);
          end
        end
        S_DATA: begin
          if (r_hs) begin
            cnt_q <= cnt_q + 8'd1;
            if (beat_err) begin
              rd_err_q <= 1'b1;
            end
            // Only rlast ends the burst, even if it arrives on the wrong beat.
            if (rlast_i) begin
              state_q  <= S_IDLE;
              last_d_q <= (grant_q == G_D);
              grant_q  <= G_NONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
